pc_sequencer: RTL
=================

# pc_sequencer

Parametrised program-counter sequencer for the simple microprocessor. It replaces the fixed 8-bit counter-plus-adder pair. Each cycle it selects the next instruction address from one of these sources: sequential increment, relative or absolute jump, conditional branch on the ALU zero flag, or call/return through an internal return-address stack. It sits between the decoder/ALU, which supply mode, offset and zero, and the instruction memory address input.

## Interface
Parameters:
- PC_W, 8, width of the program counter and instruction address.
- OFF_W, 8, width of the signed relative offset (instruction low field).
- STACK_DEPTH, 4, number of return-address entries (≥1).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  single clock, all state updates on rising edge.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  1 = hold PC and stack this cycle.
- br_mode  in  3  0 seq, 1 jump rel, 2 branch-if-zero rel, 3 branch-if-nonzero rel, 4 call rel, 5 return, 6 jump abs, 7 reserved (treated as seq).
- zero  in  1  ALU zero flag for the current instruction.
- offset  in  OFF_W  signed two's-complement relative offset.
- target  in  PC_W  absolute jump address (mode 6).
- pc  out  PC_W  registered current PC, to instruction memory.
- pc_next  out  PC_W  combinational value PC takes at next edge.
- taken  out  1  combinational; 1 when pc_next ≠ pc+1 source (any non-sequential selection).
- sp  out  clog2(STACK_DEPTH+1)  current stack occupancy.
- stack_ovf  out  1  sticky: call attempted with stack full.
- stack_unf  out  1  sticky: return attempted with stack empty.

## Operation
- Relative target = pc + sext(offset), with offset sign-extended or truncated to PC_W. This matches the existing convention of being relative to the current instruction's PC, not pc+1.
- All PC arithmetic is modulo 2^PC_W. Increment from all-ones wraps to 0. Relative targets wrap in both directions.
- Next-PC selection when stall=0:
  - mode 0/7: pc+1.
  - mode 1: rel target.
  - mode 2: rel target if zero=1, else pc+1.
  - mode 3: rel target if zero=0, else pc+1.
  - mode 4: rel target. Pushes pc+1 if sp<STACK_DEPTH. If full, the push is dropped and stack_ovf is set. The jump is still taken.
  - mode 5: if sp>0, pops the top entry into the PC. If empty, the PC takes pc+1 and stack_unf is set.
  - mode 6: target.
- Stack is LIFO. On a call, the entry is written at index sp, then sp increments. On a return, the entry at sp-1 is read, then sp decrements.
- stall=1 overrides everything:
  - pc, stack, sp and flags are held.
  - pc_next = pc.
  - taken = 0.
- stack_ovf and stack_unf clear only on reset.

## Timing
- On reset low at a rising edge, regardless of stall or br_mode:
  - pc = RESET_PC, sp = 0, stack_ovf = 0, stack_unf = 0.
  - Stack contents are don't-care.
- Reset asserted mid-call sequence: the stack is fully discarded. A following return underflows.
- With reset high, pc ← pc_next each edge. Latency from mode/zero/offset inputs to pc is one cycle. There are no delay slots.
- pc_next, taken: purely combinational from the current inputs and state.
- Return with sp>0: pc_next equals the stack top in the same cycle.
- Back-to-back call/return in consecutive cycles is supported at full rate.

## Configuration
- PCSEQ_STACK_EN defined: call/return stack built as described. sp, stack_ovf and stack_unf are live.
- PCSEQ_STACK_EN undefined:
  - No stack storage.
  - mode 4 behaves as mode 1 (jump rel, no push).
  - mode 5 behaves as mode 0.
  - sp, stack_ovf and stack_unf tied to 0.

## Test plan
- Reset/sequential: hold reset=0 for 2 edges with RESET_PC=0x10, then reset=1 and mode 0 for 3 edges → pc = 0x10, 0x11, 0x12, 0x13. Then pc=0xFF with mode 0 → 0x00.
- Conditional branch: pc=0x05, offset=0xFD (−3).
  - mode 2, zero=1 → pc=0x02, taken=1.
  - mode 2, zero=0 → pc=0x06, taken=0.
  - mode 3, zero=0 → pc=0x02.
- Call/return nesting, STACK_DEPTH=4:
  - Call at pc=0x20, offset 0x10 → pc=0x30, sp=1.
  - Call at 0x30, offset 0x08 → pc=0x38, sp=2.
  - Return → pc=0x31, sp=1.
  - Return → pc=0x21, sp=0. No flags set.
- Overflow/underflow:
  - 5 consecutive calls → sp=4, stack_ovf=1, 5th jump taken.
  - 5 returns → first 4 pop correctly, 5th gives pc+1 with stack_unf=1.
  - Both flags stay 1 until reset=0.
- Stall and reset priority:
  - stall=1 with mode 4 → pc, sp unchanged for 3 cycles, pc_next=pc.
  - reset=0 together with stall=1 and sp=2 → pc=RESET_PC, sp=0.
- Macro off (PCSEQ_STACK_EN undefined): mode 4 at pc=0x20, offset 0x10 → pc=0x30, sp=0. Then mode 5 → pc=0x31, stack_unf=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential, relative/absolute jump, conditional branch and call/return.
// Define PCSEQ_STACK_EN to build the return-address stack; without it calls are plain jumps and returns fall through.
module pc_sequencer #(
    parameter int unsigned     PC_W        = 8,
    parameter int unsigned     OFF_W       = 8,
    parameter int unsigned     STACK_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    localparam int unsigned    SP_W        = $clog2(STACK_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic [2:0]       br_mode,
    input  logic             zero,
    input  logic [OFF_W-1:0] offset,
    input  logic [PC_W-1:0]  target,
    output logic [PC_W-1:0]  pc,
    output logic [PC_W-1:0]  pc_next,
    output logic             taken,
    output logic [SP_W-1:0]  sp,
    output logic             stack_ovf,
    output logic             stack_unf
);

    localparam logic [2:0] MODE_SEQ    = 3'd0;
    localparam logic [2:0] MODE_JREL   = 3'd1;
    localparam logic [2:0] MODE_BZ     = 3'd2;
    localparam logic [2:0] MODE_BNZ    = 3'd3;
    localparam logic [2:0] MODE_CALL   = 3'd4;
    localparam logic [2:0] MODE_RET    = 3'd5;
    localparam logic [2:0] MODE_JABS   = 3'd6;

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] offExt;
    logic [PC_W-1:0] pcInc;
    logic [PC_W-1:0] relTgt;

    // Offset is sign-extended when narrower than the PC, truncated when wider.
    generate
        if (OFF_W >= PC_W) begin : gOffTrunc
            assign offExt = offset[PC_W-1:0];
        end else begin : gOffSext
            assign offExt = {{(PC_W - OFF_W){offset[OFF_W-1]}}, offset};
        end
    endgenerate

    assign pcInc  = pc_q + PC_W'(1);
    assign relTgt = pc_q + offExt;
    assign pc     = pc_q;

`ifdef PCSEQ_STACK_EN
    localparam int unsigned     IDX_W    = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SP_W-1:0] DEPTH_SP = SP_W'(STACK_DEPTH);

    logic [PC_W-1:0]  stack_q [STACK_DEPTH];
    logic [SP_W-1:0]  sp_q;
    logic             ovf_q;
    logic             unf_q;
    logic [IDX_W-1:0] pushIdx;
    logic [IDX_W-1:0] topIdx;
    logic [PC_W-1:0]  stackTop;
    logic             doPush;
    logic             doPop;
    logic             ovfSet;
    logic             unfSet;

    assign pushIdx  = IDX_W'(sp_q);
    assign topIdx   = IDX_W'(sp_q - SP_W'(1));
    assign stackTop = stack_q[topIdx];

    always_comb begin
        pc_next = pcInc;
        taken   = 1'b0;
        doPush  = 1'b0;
        doPop   = 1'b0;
        ovfSet  = 1'b0;
        unfSet  = 1'b0;
        if (stall) begin
            pc_next = pc_q;
        end else begin
            case (br_mode)
                MODE_JREL: begin
                    pc_next = relTgt;
                    taken   = 1'b1;
                end
                MODE_BZ: begin
                    if (zero) begin
                        pc_next = relTgt;
                        taken   = 1'b1;
                    end
                end
                MODE_BNZ: begin
                    if (!zero) begin
                        pc_next = relTgt;
                        taken   = 1'b1;
                    end
                end
                MODE_CALL: begin
                    // A call on a full stack still jumps; only the push is lost.
                    pc_next = relTgt;
                    taken   = 1'b1;
                    if (sp_q < DEPTH_SP) begin
                        doPush = 1'b1;
                    end else begin
                        ovfSet = 1'b1;
                    end
                end
                MODE_RET: begin
                    if (sp_q != '0) begin
                        pc_next = stackTop;
                        taken   = 1'b1;
                        doPop   = 1'b1;
                    end else begin
                        unfSet = 1'b1;
                    end
                end
                MODE_JABS: begin
                    pc_next = target;
                    taken   = 1'b1;
                end
                default: begin
                    pc_next = pcInc;
                end
            endcase
        end
    end

    // Stack contents are intentionally left out of reset; only sp decides what is valid.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q  <= RESET_PC;
            sp_q  <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (!stall) begin
            pc_q <= pc_next;
            if (doPush) begin
                stack_q[pushIdx] <= pcInc;
                sp_q             <= sp_q + SP_W'(1);
            end else if (doPop) begin
                sp_q <= sp_q - SP_W'(1);
            end
            if (ovfSet) begin
                ovf_q <= 1'b1;
            end
            if (unfSet) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign sp        = sp_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

`else
    // Without a stack, a call is a plain relative jump and a return is sequential.
    always_comb begin
        pc_next = pcInc;
        taken   = 1'b0;
        if (stall) begin
            pc_next = pc_q;
        end else begin
            case (br_mode)
                MODE_JREL, MODE_CALL: begin
                    pc_next = relTgt;
                    taken   = 1'b1;
                end
                MODE_BZ: begin
                    if (zero) begin
                        pc_next = relTgt;
                        taken   = 1'b1;
                    end
                end
                MODE_BNZ: begin
                    if (!zero) begin
                        pc_next = relTgt;
                        taken   = 1'b1;
                    end
                end
                MODE_JABS: begin
                    pc_next = target;
                    taken   = 1'b1;
                end
                MODE_SEQ, MODE_RET: begin
                    pc_next = pcInc;
                end
                default: begin
                    pc_next = pcInc;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else if (!stall) begin
            pc_q <= pc_next;
        end
    end

    assign sp        = '0;
    assign stack_ovf = 1'b0;
    assign stack_unf = 1'b0;
`endif

endmodule
